uart_rx: RTL

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop input synchronizer, mid-bit sampling FSM and a
// single-entry output holding register with overrun and framing-error flags.
module uart_rx #(
  parameter int unsigned CLK_HZ = 24000000,
  parameter int unsigned BAUD   = 115200,
  parameter int unsigned DIV    = (CLK_HZ + BAUD / 2) / BAUD
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ack,
  output logic       overrun,
  output logic       frame_err,
  output logic       busy
);

  localparam int unsigned CW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] HALF_LD = CW'(DIV / 2 - 1);
  localparam logic [CW-1:0] FULL_LD = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    sh_q, sh_d;
  logic          armed_q, armed_d;
  logic          deliver_q, deliver_d;
  logic          ferr_d;

  logic          rx_meta, rs;
  logic [1:0]    live_q;
  logic          cnt_zero;

  // live_q marks when rs carries a real line sample rather than reset fill,
  // so a line already low at reset release can never look like a falling edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_meta <= 1'b1;
      rs      <= 1'b1;
      live_q  <= '0;
    end else begin
      rx_meta <= rx;
      rs      <= rx_meta;
      live_q  <= {live_q[0], 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      sh_q      <= '0;
      armed_q   <= 1'b0;
      deliver_q <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      sh_q      <= sh_d;
      armed_q   <= armed_d;
      deliver_q <= deliver_d;
      frame_err <= ferr_d;
    end
  end

  assign cnt_zero = (cnt_q == '0);

  // armed_q records "rs seen high while idle"; detection while armed with rs
  // low is exactly the 1-to-0 transition, and a held-low break never re-arms.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    sh_d      = sh_q;
    armed_d   = armed_q;
    deliver_d = 1'b0;
    ferr_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (armed_q && !rs) begin
          state_d = START;
          cnt_d   = HALF_LD;
          armed_d = 1'b0;
        end else if (rs && live_q[1]) begin
          armed_d = 1'b1;
        end
      end
      START: begin
        if (cnt_zero) begin
          if (!rs) begin
            state_d = DATA;
            cnt_d   = FULL_LD;
            idx_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      DATA: begin
        if (cnt_zero) begin
          sh_d  = {rs, sh_q[7:1]};
          cnt_d = FULL_LD;
          if (idx_q == 3'd7) state_d = STOP;
          else               idx_d   = idx_q + 3'd1;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      STOP: begin
        if (cnt_zero) begin
          state_d   = IDLE;
          deliver_d = rs;
          ferr_d    = !rs;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Delivery coinciding with ack counts as a clean hand-off, not an overrun.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      data    <= 8'h00;
      valid   <= 1'b0;
      overrun <= 1'b0;
    end else if (deliver_q) begin
      data  <= sh_q;
      valid <= 1'b1;
      if (valid && !ack)     overrun <= 1'b1;
      else if (valid && ack) overrun <= 1'b0;
    end else if (valid && ack) begin
      valid   <= 1'b0;
      overrun <= 1'b0;
    end
  end

  assign busy = (state_q != IDLE);

endmodule
